// File: rtl/count_seq_pkg.sv
// Shared types and defaults for the count_sequencer block.
package count_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CS_WIDTH      = 4;
    localparam int CS_DEFAULT_TC = 10;
    localparam int CS_WRAP_W     = 8;
    localparam int CS_PRESCALE_W = 4;

endpackage

// File: rtl/count_seq_prescaler.sv
// Tick generator: one tick every prescale+1 enabled cycles (down-counter, terminal count 0).
// Instantiated by count_sequencer only when COUNT_SEQ_PRESCALE_EN is defined.
module count_seq_prescaler
    import count_seq_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  logic                     i_clear,
    input  logic                     i_en,
    input  logic [CS_PRESCALE_W-1:0] i_prescale,
    output logic                     o_tick
);

    logic [CS_PRESCALE_W-1:0] r_div;
    logic [CS_PRESCALE_W-1:0] r_cnt;

    assign o_tick = (r_cnt == '0);

    // Load wins over clear so a start in IDLE picks up the new divider.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_div <= i_prescale;
            r_cnt <= i_prescale;
        end else if (i_clear) begin
            r_cnt <= r_div;
        end else if (i_en) begin
            r_cnt <= o_tick ? r_div : r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Up-counter run sequencer: start/stop/pause, programmable terminal count, one-shot or auto-reload.
// Optional prescaled tick under COUNT_SEQ_PRESCALE_EN; default build ticks every cycle.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH      = CS_WIDTH,
    parameter int DEFAULT_TC = CS_DEFAULT_TC,
    parameter int WRAP_W     = CS_WRAP_W
) (
    input  logic              clk,
    input  logic              rst,
`ifdef COUNT_SEQ_PRESCALE_EN
    input  logic [3:0]        prescale,
`endif
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              mode,
    input  logic              tc_load,
    input  logic [WIDTH-1:0]  tc_in,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic [WRAP_W-1:0] wrap_cnt
);

    state_t             r_state, w_state_nx;
    logic [WIDTH-1:0]   r_count, w_count_nx;
    logic [WIDTH-1:0]   r_tc, w_tc_nx;
    logic               r_done, w_done_nx;
    logic [WRAP_W-1:0]  r_wrap, w_wrap_nx;
    logic               r_mode, w_mode_nx;
    logic               w_tick;

`ifdef COUNT_SEQ_PRESCALE_EN
    logic w_start_acc;
    logic w_pre_clear;
    logic w_pre_en;

    assign w_start_acc = ((r_state == IDLE) || (r_state == DONE)) && start && !stop;
    assign w_pre_clear = stop || (r_state == IDLE) || (r_state == DONE);
    // Only advance on cycles that actually count; the pause-entry cycle must not eat a tick.
    assign w_pre_en    = (r_state == RUN) && !stop && !pause;

    count_seq_prescaler u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_start_acc),
        .i_clear    (w_pre_clear),
        .i_en       (w_pre_en),
        .i_prescale (prescale),
        .o_tick     (w_tick)
    );
`else
    assign w_tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_tc    <= WIDTH'(DEFAULT_TC);
            r_done  <= 1'b0;
            r_wrap  <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_count <= w_count_nx;
            r_tc    <= w_tc_nx;
            r_done  <= w_done_nx;
            r_wrap  <= w_wrap_nx;
            r_mode  <= w_mode_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_tc_nx    = r_tc;
        w_done_nx  = 1'b0;
        w_wrap_nx  = r_wrap;
        w_mode_nx  = r_mode;
        case (r_state)
            IDLE, DONE: begin
                w_state_nx = IDLE;
                w_count_nx = '0;
                if (tc_load) w_tc_nx = tc_in;
                if (start && !stop) begin
                    w_state_nx = RUN;
                    w_wrap_nx  = '0;
                    w_mode_nx  = mode;
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nx = IDLE;
                    w_count_nx = '0;
                end else if (pause) begin
                    w_state_nx = HOLD;
                end else if (w_tick) begin
                    if (r_count == r_tc) begin
                        w_count_nx = '0;
                        w_done_nx  = 1'b1;
                        if (r_wrap != '1) w_wrap_nx = r_wrap + 1'b1;
                        w_state_nx = r_mode ? RUN : DONE;
                    end else begin
                        w_count_nx = r_count + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (stop) begin
                    w_state_nx = IDLE;
                    w_count_nx = '0;
                end else if (!pause) begin
                    w_state_nx = RUN;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_count_nx = '0;
            end
        endcase
    end

    assign count    = r_count;
    assign busy     = (r_state == RUN) || (r_state == HOLD);
    assign done     = r_done;
    assign wrap_cnt = r_wrap;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: table of per-cycle vectors plus hand-written corner sequences.
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       mode = 1'b0;
    logic       tc_load = 1'b0;
    logic [3:0] tc_in = 4'd0;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic [7:0] wrap_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       start, stop, pause, mode, tc_load;
        logic [3:0] tc_in;
        logic [3:0] e_count;
        logic       e_busy, e_done;
        logic [7:0] e_wrap;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    count_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .mode     (mode),
        .tc_load  (tc_load),
        .tc_in    (tc_in),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .wrap_cnt (wrap_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int c, input bit b, input bit d, input int w);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".wrap"}, 32'(wrap_cnt), 32'(w));
    endtask

    task automatic set_in(input bit s, input bit sp, input bit p, input bit m, input bit l, input int t);
        start = s; stop = sp; pause = p; mode = m; tc_load = l; tc_in = 4'(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit s, input bit sp, input bit p, input bit m, input bit l, input int t,
                       input int c, input bit b, input bit d, input int w);
        vec_t v;
        v.start = s; v.stop = sp; v.pause = p; v.mode = m; v.tc_load = l; v.tc_in = 4'(t);
        v.e_count = 4'(c); v.e_busy = b; v.e_done = d; v.e_wrap = 8'(w);
        vecs.push_back(v);
    endtask

    initial begin
        // Auto-reload with tc=3, then stop; then tc=0 in auto-reload, then stop.
        add(0,0,0,0,1,3,  0,0,0,1);
        add(1,0,0,1,0,0,  0,1,0,0);
        add(0,0,0,0,0,0,  1,1,0,0);
        add(0,0,0,0,0,0,  2,1,0,0);
        add(0,0,0,0,0,0,  3,1,0,0);
        add(0,0,0,0,0,0,  0,1,1,1);
        add(0,0,0,0,0,0,  1,1,0,1);
        add(0,0,0,0,0,0,  2,1,0,1);
        add(0,0,0,0,0,0,  3,1,0,1);
        add(0,0,0,0,0,0,  0,1,1,2);
        add(0,0,0,0,0,0,  1,1,0,2);
        add(0,0,0,0,0,0,  2,1,0,2);
        add(0,0,0,0,0,0,  3,1,0,2);
        add(0,0,0,0,0,0,  0,1,1,3);
        add(0,1,0,0,0,0,  0,0,0,3);
        add(0,0,0,0,1,0,  0,0,0,3);
        add(1,0,0,1,0,0,  0,1,0,0);
        add(0,0,0,0,0,0,  0,1,1,1);
        add(0,0,0,0,0,0,  0,1,1,2);
        add(0,0,0,0,0,0,  0,1,1,3);
        add(0,1,0,0,0,0,  0,0,0,3);

        // Reset state
        step();
        step();
        expect_out("reset", 0, 0, 0, 0);
        #10 rst = 1'b1;

        // One-shot run with default tc=10
        set_in(1,0,0,0,0,0);
        step();
        expect_out("os_start", 0, 1, 0, 0);
        set_in(0,0,0,0,0,0);
        for (int i = 1; i <= 10; i++) begin
            step();
            expect_out($sformatf("os_cnt%0d", i), i, 1, 0, 0);
        end
        step();
        expect_out("os_wrap", 0, 0, 1, 1);
        step();
        expect_out("os_idle", 0, 0, 0, 1);

        // Table vectors
        foreach (vecs[i]) begin
            set_in(vecs[i].start, vecs[i].stop, vecs[i].pause, vecs[i].mode, vecs[i].tc_load, vecs[i].tc_in);
            step();
            expect_out($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_wrap);
        end
        set_in(0,0,0,0,0,0);

        // Full-range terminal count 15
        set_in(1,0,0,0,1,15);
        step();
        expect_out("fr_start", 0, 1, 0, 0);
        set_in(0,0,0,0,0,0);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk($sformatf("fr_cnt%0d", i), 32'(count), 32'(i));
            chk($sformatf("fr_done%0d", i), 32'(done), 32'd0);
        end
        step();
        expect_out("fr_wrap", 0, 0, 1, 1);

        // Pause and stop; tc_load+start in one cycle applies tc=10 to this run
        set_in(1,0,0,0,1,10);
        step();
        expect_out("ps_start", 0, 1, 0, 0);
        set_in(0,0,0,0,0,0);
        for (int i = 1; i <= 5; i++) step();
        chk("ps_at5", 32'(count), 32'd5);
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out($sformatf("ps_hold%0d", i), 5, 1, 0, 0);
        end
        pause = 1'b0;
        step();
        expect_out("ps_resume", 5, 1, 0, 0);
        step();
        chk("ps_cnt6", 32'(count), 32'd6);
        step();
        chk("ps_cnt7", 32'(count), 32'd7);
        set_in(1,1,0,0,0,0);
        step();
        expect_out("ps_stop", 0, 0, 0, 0);
        set_in(0,0,0,0,0,0);
        step();
        expect_out("ps_after", 0, 0, 0, 0);

        // Rejected tc_load and start while busy
        set_in(1,0,0,0,0,0);
        step();
        expect_out("rj_start", 0, 1, 0, 0);
        set_in(0,0,0,0,0,0);
        for (int i = 1; i <= 4; i++) step();
        chk("rj_at4", 32'(count), 32'd4);
        set_in(0,0,0,0,1,2);
        step();
        chk("rj_tcload", 32'(count), 32'd5);
        set_in(0,0,0,0,0,0);
        step();
        set_in(1,0,0,0,0,0);
        step();
        expect_out("rj_restart", 7, 1, 0, 0);
        set_in(0,0,0,0,0,0);
        for (int i = 8; i <= 10; i++) begin
            step();
            expect_out($sformatf("rj_cnt%0d", i), i, 1, 0, 0);
        end
        step();
        expect_out("rj_wrap", 0, 0, 1, 1);
        step();
        expect_out("rj_idle", 0, 0, 0, 1);

        // Asynchronous reset mid-run restores tc=10
        set_in(1,0,0,0,1,7);
        step();
        set_in(0,0,0,0,0,0);
        for (int i = 1; i <= 6; i++) step();
        chk("rs_at6", 32'(count), 32'd6);
        #2 rst = 1'b0;
        #1;
        expect_out("rs_async", 0, 0, 0, 0);
        #3 rst = 1'b1;
        set_in(1,0,0,0,0,0);
        step();
        expect_out("rs_start", 0, 1, 0, 0);
        set_in(0,0,0,0,0,0);
        for (int i = 1; i <= 10; i++) begin
            step();
            expect_out($sformatf("rs_cnt%0d", i), i, 1, 0, 0);
        end
        step();
        expect_out("rs_wrap", 0, 0, 1, 1);
        set_in(1,0,0,0,0,0);
        step();
        expect_out("rs_done_start", 0, 1, 0, 0);
        set_in(0,0,0,0,0,0);
        step();
        chk("rs_cnt1b", 32'(count), 32'd1);
        set_in(0,1,0,0,0,0);
        step();
        expect_out("rs_stop", 0, 0, 0, 0);
        set_in(0,0,0,0,0,0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Controller that sequences an up-counter run: start/stop/pause control, programmable terminal count, one-shot or auto-reload mode.
- Sits between the control logic and the modulo-counter datapath. Owns the count register and reports completion.
- Default terminal count is 10, i.e. count sequence 0..10.

Parameters:
- WIDTH, 4, counter and terminal-count width.
- DEFAULT_TC, 10, terminal count loaded at reset.
- WRAP_W, 8, width of the wrap counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  level-sampled; begins a run from IDLE or DONE.
- stop  input  1  aborts a run; returns to IDLE with count cleared.
- pause  input  1  while high in RUN, count is frozen (HOLD).
- mode  input  1  0 = one-shot, 1 = auto-reload; sampled on the start cycle and latched for the run.
- tc_load  input  1  loads tc_in into the terminal-count register.
- tc_in  input  WIDTH  new terminal count.
- count  output  WIDTH  current count value.
- busy  output  1  high in RUN or HOLD.
- done  output  1  one-cycle pulse when count wraps from tc to 0.
- wrap_cnt  output  WRAP_W  number of wraps since last start; saturates at all-ones.

Behaviour:
- Reset (rst low, any time, including mid-run):
  - state = IDLE, count = 0, tc = DEFAULT_TC, done = 0, busy = 0, wrap_cnt = 0, latched mode = 0.
  - Takes effect immediately; the first edge after release is a normal edge.
- States: IDLE, RUN, HOLD, DONE. Command priority each cycle: stop > start > pause.
- IDLE:
  - count holds 0.
  - start=1: next state RUN, count = 0, wrap_cnt = 0, mode latched.
- RUN, on each tick (tick is constantly 1 unless the optional feature is compiled in):
  - count < tc: count <= count + 1.
  - count == tc: count <= 0 and done = 1 for exactly one cycle; wrap_cnt increments, saturating.
    - One-shot: next state DONE.
    - Auto-reload: stay in RUN.
- HOLD:
  - Entered from RUN when pause=1 and stop=0.
  - count is frozen; returns to RUN on the cycle after pause falls.
  - No tick is consumed while in HOLD.
- DONE:
  - Lasts one cycle, busy = 0, count = 0; then IDLE.
  - start=1 during DONE behaves as in IDLE and goes to RUN.
- stop=1 in RUN or HOLD: next state IDLE, count = 0, no done pulse; wrap_cnt is retained for readback.
- start while busy is ignored; the run is not restarted.
- tc_load:
  - Accepted only in IDLE or DONE; ignored while busy, so the terminal count cannot change mid-run.
  - tc_load and start in the same cycle: the new tc applies to that run.
- Boundary values:
  - tc = 0: count stays 0 and done pulses on every tick.
  - tc = 2^WIDTH-1: full-range wrap with no overflow.
- Latency:
  - start to first increment: 2 edges (edge 1 enters RUN, edge 2 gives count = 1).
  - Terminal edge to done: done is registered high on the same edge that clears count.

Optional Feature:
- Macro COUNT_SEQ_PRESCALE_EN.
- Defined:
  - Adds input prescale [3:0].
  - An internal prescaler produces tick once every prescale+1 clk cycles.
  - The prescaler clears on reset, in IDLE, on start, and on stop; it is frozen in HOLD.
  - prescale is sampled at start.
- Undefined: no port, no prescaler, tick = 1 permanently.

Decomposition:
- Package count_seq_pkg: state enum (IDLE, RUN, HOLD, DONE), DEFAULT_TC, WRAP_W.
- Optional sub-module count_seq_prescaler (tick generator), instantiated only under COUNT_SEQ_PRESCALE_EN.
- FSM and count register stay in the top module.

Test Plan:
- Reset default, one-shot run: rst low then high, mode=0, start for 1 cycle -> count 1..10, then 0; done high exactly one cycle on the 10->0 edge; state DONE then IDLE; wrap_cnt=1.
- Auto-reload: tc_load with tc_in=3, start with mode=1, run 12 ticks -> count 0,1,2,3,0,...; done pulses every 4 ticks; wrap_cnt=3; busy stays high.
- Pause and stop: pause asserted at count=5 for 4 cycles -> count stays 5, then resumes at 6. Later, stop and start high together at count=7 -> IDLE, count=0, no done pulse.
- Rejected commands: tc_load with tc_in=2 at count=4 mid-run -> ignored, run still wraps at 10. start while busy -> no restart.
- Edge cases:
  - tc_in=0 -> done every cycle.
  - rst pulsed low mid-run at count=6 -> count=0 and tc=10 asynchronously; after release, start gives a normal run.
- With COUNT_SEQ_PRESCALE_EN, prescale=2 -> count advances every 3 clk cycles; frozen during pause.
